fetch_unit: RTL

Instruction-fetch stage feeding the fetch/decode pipeline register. Holds the PC, issues one-outstanding word requests to instruction memory, buffers returned words in a small queue, and presents `inst_F`/`flush_F` to the F/D register under the same `stall_D` used there. Handles branch/jump redirects by clearing the queue and discarding any in-flight response.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, small instruction queue feeding F/D.
// Optional perf counters under `ifdef FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_D,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_F,
  output logic [31:0] pc_F,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_redirects,
`endif
  output logic        flush_F
);

  localparam int             AW   = $clog2(QDEPTH);
  localparam logic [AW:0]    QCAP = (AW+1)'(QDEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } qent_t;

  typedef enum logic {FETCH, DROP} state_t;

  state_t        state, state_n;
  logic [31:0]   pc, req_pc;
  logic          outstanding, outstanding_n;
  qent_t         q [QDEPTH];
  qent_t         head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          accept, push, pop;

  always_comb begin
    imem_req = !rst && (state == FETCH) && !redirect && !outstanding && (count < QCAP);
    accept   = imem_req && imem_ack;
    // A response arriving alongside a redirect belongs to the old path.
    push     = (state == FETCH) && outstanding && imem_rvalid && !redirect;
    pop      = (count != '0) && !stall_D && !redirect;
  end

  always_comb begin
    state_n       = state;
    outstanding_n = outstanding;
    if (redirect) begin
      if (outstanding && !imem_rvalid) begin
        state_n = DROP;
      end else begin
        state_n       = FETCH;
        outstanding_n = 1'b0;
      end
    end else if (outstanding && imem_rvalid) begin
      state_n       = FETCH;
      outstanding_n = 1'b0;
    end else if (accept) begin
      outstanding_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      outstanding <= 1'b0;
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      state       <= state_n;
      outstanding <= outstanding_n;
      if (redirect) begin
        pc     <= redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) begin
          pc     <= pc + 32'd4;
          req_pc <= pc;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= qent_t'{inst: imem_rdata, pc: req_pc};
  end

  always_comb begin
    head      = q[rd_ptr];
    imem_addr = pc;
    inst_F    = (count != '0) ? head.inst : 32'h0;
    pc_F      = (count != '0) ? head.pc   : pc;
    flush_F   = (count == '0) || redirect;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles   <= '0;
      perf_redirects <= '0;
    end else begin
      if (flush_F && !stall_D && (perf_bubbles != '1)) perf_bubbles <= perf_bubbles + 1'b1;
      if (redirect && (perf_redirects != '1))          perf_redirects <= perf_redirects + 1'b1;
    end
  end
`endif

endmodule
